// File: rtl/normalizer_pipe.sv
// ---------------------------------------------------------------------------
// normalizer_pipe_pkg / normalizer_pipe
//
// Purpose:
//    Two-stage pipelined left-shift normalizer for the shared FP32 / dual-FP16
//    datapath. Counts leading zeros per lane and shifts each lane left so that
//    its MSB is set. Stage A does the coarse shifts (16, 8) and stage B does
//    the fine shifts (4, 2, 1). A valid/ready handshake decouples the adder
//    core upstream from the rounding/packing stage downstream at full
//    throughput.
//
// Ports:
//    clk        - single clock, all state changes on the rising edge
//    rst_n      - asynchronous active-low reset
//    flush      - synchronous flush, drops all in-flight transactions
//    in_valid   - input transaction present
//    in_ready   - input accepted this cycle when in_valid is also high
//    fmt        - FP32 (one 28-bit lane) or FP16 (two 12-bit lanes)
//    X          - magnitude to normalize
//    tag_in     - opaque sideband tag, returned unchanged
//    out_valid  - result present
//    out_ready  - downstream accepts the result
//    R          - normalized value
//    Count_h    - left-shift amount of the high lane
//    Count_l    - left-shift amount of the low lane
//    zero_h     - high-lane field was all zero
//    zero_l     - low-lane field was all zero
//    fmt_out    - fmt of the result
//    tag_out    - tag of the result
// ---------------------------------------------------------------------------

package normalizer_pipe_pkg;
   typedef enum logic {
      FP32 = 1'b0,
      FP16 = 1'b1
   } fp_fmt_e;
endpackage

module normalizer_pipe
   import normalizer_pipe_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  fp_fmt_e          fmt,
   input  logic [27:0]      X,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [27:0]      R,
   output logic [4:0]       Count_h,
   output logic [4:0]       Count_l,
   output logic             zero_h,
   output logic             zero_l,
   output fp_fmt_e          fmt_out,
   output logic [TAG_W-1:0] tag_out
);

   // Coarse stage for the 28-bit lane: returns {cnt[4], cnt[3], shifted}.
   // A zero input falls through both shifts, which yields the 31 count.
   function automatic logic [29:0] coarse28(input logic [27:0] v);
      logic [27:0] t;
      logic        s16;
      logic        s8;
      t   = v;
      s16 = (t[27:12] == 16'd0);
      if (s16) t = {t[11:0], 16'd0};
      s8  = (t[27:20] == 8'd0);
      if (s8) t = {t[19:0], 8'd0};
      return {s16, s8, t};
   endfunction

   // Coarse stage for a 12-bit lane: returns {cnt[3], shifted}.
   function automatic logic [12:0] coarse12(input logic [11:0] v);
      logic [11:0] t;
      logic        s8;
      t  = v;
      s8 = (t[11:4] == 8'd0);
      if (s8) t = {t[3:0], 8'd0};
      return {s8, t};
   endfunction

   // Fine stage for the 28-bit lane: returns {cnt[2:0], shifted}.
   function automatic logic [30:0] fine28(input logic [27:0] v);
      logic [27:0] t;
      logic        s4;
      logic        s2;
      logic        s1;
      t  = v;
      s4 = (t[27:24] == 4'd0);
      if (s4) t = {t[23:0], 4'd0};
      s2 = (t[27:26] == 2'd0);
      if (s2) t = {t[25:0], 2'd0};
      s1 = !t[27];
      if (s1) t = {t[26:0], 1'b0};
      return {s4, s2, s1, t};
   endfunction

   // Fine stage for a 12-bit lane: returns {cnt[2:0], shifted}.
   function automatic logic [14:0] fine12(input logic [11:0] v);
      logic [11:0] t;
      logic        s4;
      logic        s2;
      logic        s1;
      t  = v;
      s4 = (t[11:8] == 4'd0);
      if (s4) t = {t[7:0], 4'd0};
      s2 = (t[11:10] == 2'd0);
      if (s2) t = {t[9:0], 2'd0};
      s1 = !t[11];
      if (s1) t = {t[10:0], 1'b0};
      return {s4, s2, s1, t};
   endfunction

   // Stage A registers
   logic             a_valid;
   fp_fmt_e          a_fmt;
   logic [TAG_W-1:0] a_tag;
   logic [27:0]      a_x;
   logic [1:0]       a_ch;
   logic [1:0]       a_cl;
   logic             a_zh;
   logic             a_zl;

   // Stage A next values
   logic [27:0]      a_x_d;
   logic [1:0]       a_ch_d;
   logic [1:0]       a_cl_d;
   logic             a_zh_d;
   logic             a_zl_d;
   logic [29:0]      c32;
   logic [12:0]      c16_h;
   logic [12:0]      c16_l;

   // Stage B next values
   logic [27:0]      b_r_d;
   logic [4:0]       b_ch_d;
   logic [4:0]       b_cl_d;
   logic [30:0]      f32;
   logic [14:0]      f16_h;
   logic [14:0]      f16_l;

   // Handshake
   logic             adv_a;
   logic             adv_b;
   logic             accept;

   // Each stage may advance when it is empty or when the stage after it is
   // moving. in_ready is held low during flush and while reset is asserted so
   // nothing is lost to a dropped stage.
   always_comb begin
      adv_b    = !out_valid || out_ready;
      adv_a    = !a_valid || adv_b;
      in_ready = adv_a && !flush && rst_n;
      accept   = in_valid && in_ready;
   end

   // Coarse shift of the incoming value. In FP16 the two lanes are handled
   // separately and X[15:12] is dropped, so the lanes can never leak bits
   // into each other. Zero flags are taken from the raw fields here because
   // the shifted value alone cannot tell a zero lane from a normalized one
   // later on without the counts.
   always_comb begin
      a_x_d  = '0;
      a_ch_d = '0;
      a_cl_d = '0;
      a_zh_d = 1'b0;
      a_zl_d = 1'b0;
      c32    = coarse28(X);
      c16_h  = coarse12(X[27:16]);
      c16_l  = coarse12(X[11:0]);
      if (fmt == FP32) begin
         a_x_d  = c32[27:0];
         a_ch_d = c32[29:28];
         a_cl_d = c32[29:28];
         a_zh_d = (X == 28'd0);
         a_zl_d = (X == 28'd0);
      end else begin
         a_x_d  = {c16_h[11:0], 4'd0, c16_l[11:0]};
         a_ch_d = {1'b0, c16_h[12]};
         a_cl_d = {1'b0, c16_l[12]};
         a_zh_d = (X[27:16] == 12'd0);
         a_zl_d = (X[11:0] == 12'd0);
      end
   end

   // Stage A register. Payload only loads on an actual accept; the valid
   // bit follows in_valid whenever the stage advances so a bubble clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_fmt   <= FP32;
         a_tag   <= '0;
         a_x     <= '0;
         a_ch    <= '0;
         a_cl    <= '0;
         a_zh    <= 1'b0;
         a_zl    <= 1'b0;
      end else if (flush) begin
         a_valid <= 1'b0;
      end else if (adv_a) begin
         a_valid <= in_valid;
         if (accept) begin
            a_fmt <= fmt;
            a_tag <= tag_in;
            a_x   <= a_x_d;
            a_ch  <= a_ch_d;
            a_cl  <= a_cl_d;
            a_zh  <= a_zh_d;
            a_zl  <= a_zl_d;
         end
      end
   end

   // Fine shift of the stage A value and assembly of the final counts. The
   // coarse bits from stage A sit on top of the three fine bits found here.
   always_comb begin
      b_r_d  = '0;
      b_ch_d = '0;
      b_cl_d = '0;
      f32    = fine28(a_x);
      f16_h  = fine12(a_x[27:16]);
      f16_l  = fine12(a_x[11:0]);
      if (a_fmt == FP32) begin
         b_r_d  = f32[27:0];
         b_ch_d = {a_ch, f32[30:28]};
         b_cl_d = {a_ch, f32[30:28]};
      end else begin
         b_r_d  = {f16_h[11:0], 4'd0, f16_l[11:0]};
         b_ch_d = {a_ch, f16_h[14:12]};
         b_cl_d = {a_cl, f16_l[14:12]};
      end
   end

   // Stage B register, which is also the output register. When stalled
   // (out_valid && !out_ready) nothing here changes, so the result stays put
   // until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         R         <= '0;
         Count_h   <= '0;
         Count_l   <= '0;
         zero_h    <= 1'b0;
         zero_l    <= 1'b0;
         fmt_out   <= FP32;
         tag_out   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (adv_b) begin
         out_valid <= a_valid;
         if (a_valid) begin
            R       <= b_r_d;
            Count_h <= b_ch_d;
            Count_l <= b_cl_d;
            zero_h  <= a_zh;
            zero_l  <= a_zl;
            fmt_out <= a_fmt;
            tag_out <= a_tag;
         end
      end
   end

endmodule

// File: doc/normalizer_pipe.md
# normalizer_pipe

Pipelined, handshaked left-shift normalizer for the shared FP32/dual-FP16 datapath. It is the inverse-direction partner of the alignment right-shifter. It takes a post-add/subtract magnitude, counts leading zeros per lane, and shifts the value left so the MSB of each lane is set. It sits between the adder core and the rounding/packing stage, and decouples them with a valid/ready interface at full throughput.

## Interface
- TAG_W, 4: width of the opaque sideband tag carried alongside each transaction.
- clk, input, 1: single clock. All state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous flush. Drops all in-flight transactions.
- in_valid, input, 1: input transaction present.
- in_ready, output, 1: block accepts the input this cycle.
- fmt, input, fp_fmt_e: FP32 (one 28-bit lane) or FP16 (two 12-bit lanes).
- X, input, 28: value to normalize.
- tag_in, input, TAG_W: sideband tag, returned unchanged.
- out_valid, output, 1: result present.
- out_ready, input, 1: downstream accepts the result.
- R, output, 28: normalized value.
- Count_h, output, 5: left-shift amount for the high lane.
- Count_l, output, 5: left-shift amount for the low lane.
- zero_h, output, 1: high-lane field was all zero.
- zero_l, output, 1: low-lane field was all zero.
- fmt_out, output, fp_fmt_e: fmt of the result.
- tag_out, output, TAG_W: tag of the result.

## Operation
- FP32 lane field is X[27:0].
  - Count = number of leading zeros of X. R = X << Count.
  - Count_h = Count_l = Count.
  - X == 0: Count_h = Count_l = 31, R = 0, zero_h = zero_l = 1.
- FP16 lane fields: high = X[27:16], low = X[11:0]. X[15:12] is ignored.
  - Each lane is normalized independently: Count = lzc(field) in 0..11.
  - R[27:16] = high << Count_h. R[11:0] = low << Count_l. R[15:12] = 0.
  - Count_h[4] = Count_l[4] = 0.
  - An all-zero field gives Count = 15, lane result 0, and the lane's zero flag = 1.
- Stage A (registered): coarse shift.
  - FP32: shift by 16 if X[27:12] == 0, then by 8 if the top 8 bits are zero.
  - FP16: shift each lane by 8 if its top 8 bits are zero.
  - Count bits 4:3 are decided here.
- Stage B (registered): fine shifts by 4, 2, 1, using the same MSB-zero tests. Count bits 2:0 are decided here.
- Shifted-in bits are zero. Lanes never exchange bits in FP16.
- fmt and tag travel with the data through both stages.
- Handshake and flow control:
  - advB = !vB || out_ready.
  - advA = !vA || advB.
  - in_ready = advA, forced to 0 while rst_n is low.
  - Accept occurs when in_valid && in_ready.
  - Stage B loads from A when advB. Stage A loads from the input when advA.
  - A stage's valid clears when it advances with no upstream data.
- Payload stability:
  - out_valid is never withdrawn without out_ready or flush.
  - R, counts, flags and tag hold stable while out_valid && !out_ready.
- Flush: at the next edge vA = vB = 0. Any input presented in the flush cycle is not accepted (in_ready = 0 while flush = 1).

## Timing
- Latency: a transaction accepted at edge N is presented on out_valid after edge N+2, assuming no backpressure.
- Throughput: 1 transaction per cycle when out_ready is held high.
- Buffering: capacity is 2 transactions. With out_ready low, at most 2 transactions are accepted, then in_ready drops.
- Ordering: strict FIFO, with no loss or duplication under any out_ready pattern.
- Reset:
  - out_valid = 0. R = 0. Count_h = Count_l = 0. zero_h = zero_l = 0. tag_out = 0. fmt_out = FP32.
  - Internal valids = 0.
  - Reset mid-operation discards all transactions. in_ready returns to 1 on the first cycle after release.
- Simultaneous events:
  - Accept and drain in the same cycle are both honoured.
  - flush overrides accept and drain. A result offered in the flush cycle with out_ready = 1 counts as consumed.
- Outputs are registered. in_ready is combinational from out_ready, flush and internal valids.

## Test plan
- FP32, X = 28'h0000001, out_ready = 1:
  - out_valid exactly 2 cycles after accept.
  - R = 28'h8000000, Count_h = Count_l = 27, zero flags = 0.
- FP32, X = 0:
  - R = 0, Count_h = Count_l = 31, zero_h = zero_l = 1.
- FP16, X = 28'h010F800 (high field 12'h010, X[15:12] = 4'hF, low field 12'h800):
  - Count_h = 7, Count_l = 0, R = 28'h8000800.
- FP16, X = 28'h0000001:
  - Count_h = 15, zero_h = 1, Count_l = 11, R = 28'h0000800.
- Backpressure: out_ready = 0 for 6 cycles while 4 tagged inputs (tags 1..4) are offered back-to-back:
  - Exactly tags 1 and 2 are accepted, then in_ready = 0.
  - Output holds stable during the stall.
  - After out_ready = 1, tags 1, 2, 3, 4 emerge in order, one per cycle.
- Flush and reset:
  - Flush with 2 transactions in flight: out_valid = 0 on the next cycle, and the next accepted tag is the first result out.
  - rst_n pulsed low mid-stream: outputs show their reset values immediately (asynchronous), with no stale result after release.
